// File: rtl/spi_prog_master.sv
// SPI mode-0 initiator: one start pulse sends one NUM_BITS word LSB first,
// framed by an active-low CS, with every output driven straight from a register.
module spi_prog_master #(
  parameter int NUM_BITS = 58,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BITS-1:0] data_in,
  output logic                busy,
  output logic                done,
  output logic                SCLK,
  output logic                SDI,
  output logic                CS
);

  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t              state, state_nxt;
  logic [PH_W-1:0]     phase, phase_nxt;
  logic [BIT_W-1:0]    bitcnt, bitcnt_nxt;
  logic [NUM_BITS-1:0] shreg, shreg_nxt, shreg_shift;
  logic                busy_nxt, done_nxt, sclk_nxt, sdi_nxt, cs_nxt;
  logic                phase_end;

  assign phase_end   = (phase == PH_LAST);
  assign shreg_shift = shreg >> 1;

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    sclk_nxt   = SCLK;
    sdi_nxt    = SDI;
    cs_nxt     = CS;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SETUP;
          shreg_nxt  = data_in;
          sdi_nxt    = data_in[0];
          cs_nxt     = 1'b0;
          busy_nxt   = 1'b1;
          phase_nxt  = '0;
          bitcnt_nxt = '0;
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_nxt = HIGH;
          sclk_nxt  = 1'b1;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_ONE;
        end
      end
      HIGH: begin
        // SDI moves only on the falling SCLK edge, a full half-period before the next rise
        if (phase_end) begin
          phase_nxt = '0;
          sclk_nxt  = 1'b0;
          if (bitcnt == BIT_LAST) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = LOW;
            shreg_nxt = shreg_shift;
            sdi_nxt   = shreg_shift[0];
          end
        end else begin
          phase_nxt = phase + PH_ONE;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_nxt  = HIGH;
          sclk_nxt   = 1'b1;
          bitcnt_nxt = bitcnt + BIT_ONE;
          phase_nxt  = '0;
        end else begin
          phase_nxt = phase + PH_ONE;
        end
      end
      HOLD: begin
        if (phase_end) begin
          state_nxt = GAP;
          cs_nxt    = 1'b1;
          sdi_nxt   = 1'b0;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_ONE;
        end
      end
      GAP: begin
        if (phase_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      phase  <= '0;
      bitcnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      SCLK   <= 1'b0;
      SDI    <= 1'b0;
      CS     <= 1'b1;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      bitcnt <= bitcnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      SCLK   <= sclk_nxt;
      SDI    <= sdi_nxt;
      CS     <= cs_nxt;
    end
  end

  // The word register is pure data and is always loaded before use, so it has no reset
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_spi_prog_master.sv
// Randomised bench for spi_prog_master: a frame-timing model predicts every output
// each cycle, and a slave model checks the latched word after each frame.
module tb_spi_prog_master;
  localparam int N = 58;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] st = 2'b00;
  logic [N-1:0] dw [2];
  logic busy0, done0, sclk0, sdi0, cs0;
  logic busy1, done1, sclk1, sdi1, cs1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_prog_master #(.NUM_BITS(N), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .start(st[0]), .data_in(dw[0]),
    .busy(busy0), .done(done0), .SCLK(sclk0), .SDI(sdi0), .CS(cs0));

  spi_prog_master #(.NUM_BITS(N), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(st[1]), .data_in(dw[1]),
    .busy(busy1), .done(done1), .SCLK(sclk1), .SDI(sdi1), .CS(cs1));

  function automatic int divof(input int c);
    return (c == 0) ? 2 : 1;
  endfunction

  function automatic logic [4:0] obs(input int c);
    return (c == 0) ? {cs0, sclk0, sdi0, busy0, done0} : {cs1, sclk1, sdi1, busy1, done1};
  endfunction

  // Expected {CS,SCLK,SDI,busy,done}, n edges after the accepting edge
  function automatic logic [4:0] expect_out(input bit act, input int n,
                                            input logic [N-1:0] w, input int d);
    int l, t, idx;
    logic s;
    l = d * (2 * N + 1);
    t = d * (2 * N + 2);
    if (!act) return 5'b10000;
    if (n < l) begin
      s = (n >= d) && (n < 2 * N * d) && ((((n - d) / d) % 2) == 0);
      idx = n / (2 * d);
      if (idx > N - 1) idx = N - 1;
      return {1'b0, s, w[idx], 1'b1, 1'b0};
    end
    if (n < t) return 5'b10010;
    return 5'b10001;
  endfunction

  bit         m_act [2];
  int         m_n   [2];
  logic [N-1:0] m_w [2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        m_act[c] <= 1'b0;
        m_n[c]   <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (!(m_act[c] && m_n[c] < divof(c) * (2 * N + 2)) && st[c]) begin
          m_act[c] <= 1'b1;
          m_n[c]   <= 0;
          m_w[c]   <= dw[c];
        end else if (m_act[c]) begin
          if (m_n[c] >= divof(c) * (2 * N + 2)) m_act[c] <= 1'b0;
          else m_n[c] <= m_n[c] + 1;
        end
      end
    end
  end

  int rises [2], lows [2], lat [2], dones [2], frames [2];
  int fall_cyc [2], rise_cyc [2];
  int low_h [2][4], gap_h [2][4];
  logic [N-1:0] cap [2], sl_sr [2], sl_word [2];
  logic pcs [2], psclk [2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic compare_loop();
    logic [4:0] e, a;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        e = expect_out(m_act[c], m_n[c], m_w[c], divof(c));
        a = obs(c);
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_outputs ch%0d cyc %0d {cs,sclk,sdi,busy,done}: got %b, want %b",
                   c, cyc, a, e);
        end
      end
    end
  endtask

  // Bus monitor plus slave: shifts SDI in MSB-ward on each SCLK rise, latches on CS rise
  task automatic monitor_loop();
    logic [4:0] a;
    int k;
    for (int c = 0; c < 2; c++) begin
      pcs[c] = 1'b1; psclk[c] = 1'b0; rises[c] = 0; dones[c] = 0; frames[c] = 0;
      rise_cyc[c] = -1; sl_sr[c] = '0; sl_word[c] = '0; cap[c] = '0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        a = obs(c);
        if (!reset) begin
          rises[c] = 0; sl_sr[c] = '0; pcs[c] = 1'b1; psclk[c] = 1'b0; rise_cyc[c] = -1;
        end else begin
          if (pcs[c] && !a[4]) begin
            frames[c]++;
            rises[c] = 0;
            fall_cyc[c] = cyc;
            k = (frames[c] - 1) % 4;
            gap_h[c][k] = (rise_cyc[c] >= 0) ? cyc - rise_cyc[c] : -1;
          end
          if (!a[4] && a[3] && !psclk[c]) begin
            if (rises[c] < N) cap[c][rises[c]] = a[2];
            sl_sr[c] = {a[2], sl_sr[c][N-1:1]};
            rises[c]++;
          end
          if (!pcs[c] && a[4]) begin
            lows[c] = cyc - fall_cyc[c];
            low_h[c][(frames[c] - 1) % 4] = lows[c];
            rise_cyc[c] = cyc;
            sl_word[c] = sl_sr[c];
          end
          if (a[0]) begin
            dones[c]++;
            lat[c] = cyc - fall_cyc[c];
          end
          pcs[c] = a[4];
          psclk[c] = a[3];
        end
      end
    end
  endtask

  task automatic send(input int c, input logic [N-1:0] w);
    @(negedge clk);
    dw[c] = w;
    st[c] = 1'b1;
    @(negedge clk);
    st[c] = 1'b0;
  endtask

  task automatic wait_done(input int c, input int d0);
    for (int i = 0; i < 1000 && dones[c] == d0; i++) @(posedge clk);
    check("done_timeout", dones[c] != d0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input string name, input int c);
    check(name, obs(c), 5'b10000);
  endtask

  logic [N-1:0] w, wa;
  int d0, f0, i;

  initial begin
    dw[0] = '0;
    dw[1] = '0;
    fork
      monitor_loop();
      compare_loop();
    join_none
    #1 reset = 1'b0;
    #2 check_idle("reset_initial_ch0", 0);
    check_idle("reset_initial_ch1", 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame with hand-computed timing
    d0 = dones[0];
    w = 58'h2AB_CDEF_0123_4567;
    send(0, w);
    wait_done(0, d0);
    check("sclk_rises", rises[0], 58);
    check("cs_low_cycles", lows[0], 234);
    check("done_latency", lat[0], 236);
    check("done_pulses", dones[0] - d0, 1);
    check("sdi_bits", cap[0], 58'h2AB_CDEF_0123_4567);
    check("slave_word", sl_word[0], 58'h2AB_CDEF_0123_4567);

    // Loopback of all-ones then all-zeros
    d0 = dones[0];
    send(0, {N{1'b1}});
    wait_done(0, d0);
    check("slave_ones", sl_word[0], 58'h3FF_FFFF_FFFF_FFFF);
    check("gthdr_ones", sl_word[0][57:50], 8'hFF);
    d0 = dones[0];
    send(0, '0);
    wait_done(0, d0);
    check("slave_zeros", sl_word[0], 58'h0);
    check("gthdr_zeros", sl_word[0][57:50], 8'h00);

    // Start and data changes mid-frame are ignored
    d0 = dones[0];
    f0 = frames[0];
    wa = 58'h155_5555_AAAA_0F0F;
    send(0, wa);
    repeat (10) @(negedge clk);
    dw[0] = 58'h0AA_AAAA_5555_F0F0;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (5) @(negedge clk);
    dw[0] = 58'h123_4567_89AB_CDEF;
    wait_done(0, d0);
    repeat (5) @(negedge clk);
    check("robust_frames", frames[0] - f0, 1);
    check("robust_word", sl_word[0], 58'h155_5555_AAAA_0F0F);

    // Reset at bit 20
    d0 = dones[0];
    w = N'({$urandom, $urandom});
    send(0, w);
    for (i = 0; i < 400 && rises[0] < 21; i++) @(posedge clk);
    check("bit20_timeout", rises[0] >= 21, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check_idle("reset_mid_frame", 0);
    check("reset_mid_busy", busy0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", dones[0] - d0, 0);
    d0 = dones[0];
    w = N'({$urandom, $urandom});
    send(0, w);
    wait_done(0, d0);
    check("post_reset_word", sl_word[0], w);
    check("post_reset_rises", rises[0], N);

    // Randomised frames with stray start pulses
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      d0 = dones[0];
      w = N'({$urandom, $urandom});
      send(0, w);
      repeat ($urandom_range(20, 120)) @(negedge clk);
      dw[0] = N'({$urandom, $urandom});
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      wait_done(0, d0);
      check("random_word", sl_word[0], w);
    end

    // CLK_DIV=1 instance, start held for three frames
    d0 = dones[1];
    f0 = frames[1];
    w = N'({$urandom, $urandom});
    @(negedge clk);
    dw[1] = w;
    st[1] = 1'b1;
    for (i = 0; i < 600 && frames[1] - f0 < 3; i++) @(posedge clk);
    @(negedge clk);
    st[1] = 1'b0;
    for (i = 0; i < 600 && dones[1] - d0 < 3; i++) @(posedge clk);
    repeat (5) @(negedge clk);
    check("div1_frames", frames[1] - f0, 3);
    check("div1_dones", dones[1] - d0, 3);
    check("div1_low0", low_h[1][0], 117);
    check("div1_low1", low_h[1][1], 117);
    check("div1_low2", low_h[1][2], 117);
    check("div1_gap1", gap_h[1][1], 2);
    check("div1_gap2", gap_h[1][2], 2);
    check("div1_word", sl_word[1], w);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
